fft_frame_ctrl: RTL and testbench
=================================

# fft_frame_ctrl

Frame-level sequencer for the 16-point FFT datapath. It collects one frame of ADC samples into the FFT input memory using the FFT's `insert_data`/`addr`/`data_in` write port. It then waits for `fft_finish`, fires the SPI output block, and waits for that transfer to drain. Depending on mode it either stops or starts the next frame. It replaces the free-running counter/ROM stimulus in the top level with a controlled, handshaken frame loop.

## Interface

Parameters:
- `N_POINTS`, default 16: samples per frame. Must be a power of two and equal to the FFT size.
- `ADDR_W`, default 4: width of `addr`; equals log2(`N_POINTS`).
- `DATA_W`, default 16: sample width.
- `FFT_TIMEOUT`, default 4096: maximum cycles spent in WAIT_FFT before aborting.

Ports:
- `clk`, in, 1: system clock (16 MHz). All logic is on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `enable`, in, 1: continuous mode; frames repeat while high.
- `single_shot`, in, 1: one-cycle pulse; runs exactly one frame from IDLE.
- `clear_err`, in, 1: one-cycle pulse; clears `overrun` and `timeout_err`.
- `sample_valid`, in, 1: `sample_in` carries a new sample this cycle.
- `sample_in`, in, `DATA_W`: ADC sample.
- `insert_data`, out, 1: FFT input write strobe.
- `data_out`, out, `DATA_W`: sample presented to the FFT `data_in`.
- `addr`, out, `ADDR_W`: FFT input write address.
- `fft_finish`, in, 1: FFT done pulse.
- `start_spi`, out, 1: one-cycle pulse that launches the SPI result dump.
- `spi_busy`, in, 1: SPI transfer in progress.
- `busy`, out, 1: high in every state except IDLE.
- `frame_count`, out, 16: number of completed frames. Wraps from 0xFFFF to 0.
- `overrun`, out, 1: sticky; a sample was dropped.
- `timeout_err`, out, 1: sticky; `fft_finish` did not arrive within `FFT_TIMEOUT` cycles.

## Operation

- States are IDLE, COLLECT, WAIT_FFT, START_SPI and WAIT_SPI.
- **IDLE**
  - If `enable` or `single_shot` is high, go to COLLECT with the sample index cleared to 0.
  - If both are high, behaviour is the same as `enable` alone.
  - The mode (continuous or single) is latched on leaving IDLE.
- **COLLECT**
  - Each cycle with `sample_valid=1` registers `sample_in` into `data_out`, the current index into `addr`, and sets `insert_data=1` for one cycle. The index then increments.
  - Back-to-back `sample_valid` is legal and gives `insert_data` high for consecutive cycles.
  - When the write with index `N_POINTS-1` is issued, the index wraps to 0 and the state goes to WAIT_FFT.
- **WAIT_FFT**
  - Waits for `fft_finish=1`, then goes to START_SPI.
  - A cycle counter starts at 0 on entry. If it reaches `FFT_TIMEOUT` first: set `timeout_err`, go to IDLE, and do not increment `frame_count`.
- **START_SPI**: `start_spi=1` for exactly one cycle, then go to WAIT_SPI.
- **WAIT_SPI**
  - A 2-cycle guard ignores `spi_busy`, so the SPI block has time to raise it.
  - After the guard, the first cycle with `spi_busy=0` increments `frame_count`.
  - Next state is COLLECT if the latched mode is continuous and `enable` is still high; otherwise IDLE.
- `enable` is sampled only at frame boundaries. Dropping it mid-frame lets the current frame finish.
- A `sample_valid` seen in WAIT_FFT, START_SPI or WAIT_SPI is dropped and sets `overrun`. In IDLE, `sample_valid` is ignored and does not set `overrun`.
- `fft_finish` outside WAIT_FFT is ignored.
- `clear_err` clears both sticky flags. If a set condition occurs in the same cycle, the set wins.

## Timing

- **Reset values**: state IDLE, `insert_data=0`, `data_out=0`, `addr=0`, `start_spi=0`, `busy=0`, `frame_count=0`, `overrun=0`, `timeout_err=0`, index 0, counters 0.
- **Reset mid-operation**: reset forces IDLE immediately (asynchronously). No further strobes are issued, and a partial frame is discarded.
- All outputs are registered.
- **Write latency**: `sample_valid` in cycle t gives `insert_data`/`data_out`/`addr` in cycle t+1.
- **Fastest frame**: 16 valid cycles, then 1 cycle to WAIT_FFT.
- `fft_finish` in cycle t gives `start_spi` in cycle t+1.
- `start_spi` in cycle t: the earliest `spi_busy` sample is in cycle t+3, and the earliest `frame_count` update is visible in cycle t+4.
- `busy` rises the cycle after leaving IDLE and falls the cycle after returning to IDLE.

## Test plan

- **Single-shot frame**: `single_shot` pulse, then 16 consecutive `sample_valid` with values 0x0000..0x000F.
  - `insert_data` is high for 16 cycles, with `addr` 0..15 matching the data, each one cycle after its `sample_valid`.
  - `fft_finish` after 50 cycles gives one `start_spi` pulse.
  - `spi_busy` high for 300 cycles, then low: `frame_count=1`, state IDLE, `busy=0`.
- **Continuous mode**: `enable=1`, with samples every 4th cycle over 3 frames.
  - `frame_count` steps 1, 2, 3.
  - Deassert `enable` during frame 3 collection: frame 3 completes, then IDLE.
- **Overrun**: a `sample_valid` during WAIT_FFT sets `overrun=1`, with no `insert_data` and `addr` unchanged.
  - A `clear_err` pulse returns `overrun` to 0.
- **Timeout**: no `fft_finish` after collection.
  - `timeout_err=1` exactly `FFT_TIMEOUT` cycles after entering WAIT_FFT.
  - State returns to IDLE, `start_spi` never fires, and `frame_count` is unchanged.
- **Reset mid-frame**: assert `rst` after 7 samples.
  - All outputs take their reset values at once.
  - The next `single_shot` frame starts writing at `addr=0`.
- **Wrap**: preset 0xFFFF frames by forcing or running; one more frame gives `frame_count=0x0000`.

Source files
------------

// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - frame sequencer: ADC collect, FFT wait, SPI dump, repeat
module fft_frame_ctrl #(
  parameter int N_POINTS    = 16,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 16,
  parameter int FFT_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              single_shot,
  input  logic              clear_err,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  output logic              insert_data,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] addr,
  input  logic              fft_finish,
  output logic              start_spi,
  input  logic              spi_busy,
  output logic              busy,
  output logic [15:0]       frame_count,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int TO_W = $clog2(FFT_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_WAIT_FFT,
    S_START_SPI,
    S_WAIT_SPI
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] idx;
  logic              cont_mode;
  logic [TO_W-1:0]   to_cnt;
  logic [1:0]        guard;

  logic wr_fire;
  logic frame_done;
  logic to_hit;
  logic drop_sample;

  always_comb begin
    state_nx    = state;
    wr_fire     = 1'b0;
    frame_done  = 1'b0;
    to_hit      = 1'b0;
    drop_sample = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable || single_shot) state_nx = S_COLLECT;
      end
      S_COLLECT: begin
        if (sample_valid) begin
          wr_fire = 1'b1;
          if (idx == ADDR_W'(N_POINTS - 1)) state_nx = S_WAIT_FFT;
        end
      end
      S_WAIT_FFT: begin
        drop_sample = sample_valid;
        if (fft_finish) begin
          state_nx = S_START_SPI;
        end else if (to_cnt == TO_W'(FFT_TIMEOUT - 1)) begin
          to_hit   = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_START_SPI: begin
        drop_sample = sample_valid;
        state_nx    = S_WAIT_SPI;
      end
      S_WAIT_SPI: begin
        drop_sample = sample_valid;
        // spi_busy is only trusted once the guard has given the SPI block time to raise it
        if (guard == 2'd2 && !spi_busy) begin
          frame_done = 1'b1;
          state_nx   = (cont_mode && enable) ? S_COLLECT : S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      cont_mode   <= 1'b0;
      to_cnt      <= '0;
      guard       <= '0;
      insert_data <= 1'b0;
      data_out    <= '0;
      addr        <= '0;
      start_spi   <= 1'b0;
      busy        <= 1'b0;
      frame_count <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      busy        <= (state_nx != S_IDLE);
      insert_data <= wr_fire;
      start_spi   <= (state_nx == S_START_SPI);

      if (state == S_IDLE && state_nx == S_COLLECT) begin
        cont_mode <= enable;
        idx       <= '0;
      end

      if (wr_fire) begin
        data_out <= sample_in;
        addr     <= idx;
        idx      <= idx + 1'b1;
      end

      to_cnt <= (state == S_WAIT_FFT) ? to_cnt + 1'b1 : '0;

      if (state != S_WAIT_SPI) guard <= '0;
      else if (guard != 2'd2)  guard <= guard + 1'b1;

      if (frame_done) frame_count <= frame_count + 1'b1;

      if (drop_sample)    overrun <= 1'b1;
      else if (clear_err) overrun <= 1'b0;

      if (to_hit)         timeout_err <= 1'b1;
      else if (clear_err) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb/tb_fft_frame_ctrl.sv - self-checking bench for fft_frame_ctrl
`timescale 1ns/1ps
module tb_fft_frame_ctrl;

  localparam int TO = 200;

  logic        clk = 1'b0;
  logic        rst, enable, single_shot, clear_err, sample_valid, fft_finish, spi_busy;
  logic [15:0] sample_in;
  logic        insert_data;
  logic [15:0] data_out;
  logic [3:0]  addr;
  logic        start_spi, busy;
  logic [15:0] frame_count;
  logic        overrun, timeout_err;

  fft_frame_ctrl #(
    .N_POINTS(16), .ADDR_W(4), .DATA_W(16), .FFT_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .single_shot(single_shot),
    .clear_err(clear_err), .sample_valid(sample_valid), .sample_in(sample_in),
    .insert_data(insert_data), .data_out(data_out), .addr(addr),
    .fft_finish(fft_finish), .start_spi(start_spi), .spi_busy(spi_busy),
    .busy(busy), .frame_count(frame_count), .overrun(overrun),
    .timeout_err(timeout_err)
  );

  always #31 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int spi_pulses = 0;

  logic [3:0]  obs_addr[$];
  logic [15:0] obs_data[$];
  int          obs_cyc[$];
  logic [3:0]  exp_addr[$];
  logic [15:0] exp_data[$];
  int          exp_cyc[$];
  int          wr_idx = 0;
  logic [15:0] exp_fc = 16'h0;

  always @(negedge clk) begin
    if (insert_data === 1'b1) begin
      obs_addr.push_back(addr);
      obs_data.push_back(data_out);
      obs_cyc.push_back(cyc);
    end
    if (start_spi === 1'b1) spi_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    exp_addr.push_back(4'(wr_idx));
    exp_data.push_back(v);
    exp_cyc.push_back(cyc + 1);
    wr_idx = (wr_idx + 1) % 16;
    tick;
    sample_valid = 1'b0;
  endtask

  task automatic collect(input int n, input int gap, input bit ramp, input bit fixed_gap);
    for (int i = 0; i < n; i++) begin
      int g;
      g = fixed_gap ? gap : int'($urandom_range(gap, 0));
      repeat (g) tick;
      send(ramp ? 16'(i) : 16'($urandom));
    end
  endtask

  task automatic clear_queues;
    obs_addr.delete(); obs_data.delete(); obs_cyc.delete();
    exp_addr.delete(); exp_data.delete(); exp_cyc.delete();
  endtask

  task automatic check_writes(input string tag);
    int n;
    tick;
    tick;
    check({tag, "_nwrites"}, obs_addr.size(), exp_addr.size());
    n = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, obs_addr[i], exp_addr[i]);
      check({tag, "_data"}, obs_data[i], exp_data[i]);
      check({tag, "_lat"},  obs_cyc[i],  exp_cyc[i]);
    end
    clear_queues();
  endtask

  task automatic finish_frame(input int fft_delay, input int busy_len, input bit exact);
    int p0;
    int k;
    repeat (fft_delay) tick;
    p0 = spi_pulses;
    fft_finish = 1'b1;
    tick;
    fft_finish = 1'b0;
    @(negedge clk);
    check("start_spi_lat", start_spi, 1'b1);
    tick;
    if (exact) begin
      repeat (2) tick;
      @(negedge clk);
      check("fc_hold_t3", frame_count, exp_fc);
      tick;
      @(negedge clk);
      exp_fc = exp_fc + 16'd1;
      check("fc_update_t4", frame_count, exp_fc);
    end else begin
      spi_busy = 1'b1;
      repeat (busy_len) tick;
      spi_busy = 1'b0;
      exp_fc = exp_fc + 16'd1;
      k = 0;
      while (frame_count !== exp_fc && k < 20) begin
        tick;
        @(negedge clk);
        k++;
      end
      check("fc_step", frame_count, exp_fc);
    end
    check("spi_pulse_count", spi_pulses - p0, 1);
  endtask

  task automatic pulse_single;
    single_shot = 1'b1;
    tick;
    single_shot = 1'b0;
  endtask

  initial begin
    #(62 * 60000);
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    rst = 1'b1; enable = 1'b0; single_shot = 1'b0; clear_err = 1'b0;
    sample_valid = 1'b0; sample_in = 16'h0; fft_finish = 1'b0; spi_busy = 1'b0;
    repeat (3) tick;
    check("rst_insert", insert_data, 1'b0);
    check("rst_data", data_out, 16'h0);
    check("rst_addr", addr, 4'h0);
    check("rst_start_spi", start_spi, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_fc", frame_count, 16'h0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_timeout", timeout_err, 1'b0);
    rst = 1'b0;
    tick;

    // idle ignores samples and fft_finish
    sample_valid = 1'b1; fft_finish = 1'b1; sample_in = 16'hBEEF;
    tick;
    sample_valid = 1'b0; fft_finish = 1'b0;
    repeat (2) tick;
    @(negedge clk);
    check("idle_overrun", overrun, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_writes", obs_addr.size(), 0);
    check("idle_spi", spi_pulses, 0);

    // single-shot ramp frame
    pulse_single();
    collect(16, 0, 1'b1, 1'b1);
    check_writes("ss");
    @(negedge clk);
    check("ss_busy", busy, 1'b1);
    finish_frame(48, 300, 1'b0);
    repeat (2) tick;
    @(negedge clk);
    check("ss_idle_busy", busy, 1'b0);
    check("ss_fc", frame_count, 16'd1);

    // exact start_spi -> frame_count timing, random data and gaps
    pulse_single();
    collect(16, 2, 1'b0, 1'b0);
    check_writes("tm");
    finish_frame(5, 0, 1'b1);
    repeat (2) tick;
    @(negedge clk);
    check("tm_idle", busy, 1'b0);

    // continuous mode, sample every 4th cycle, enable dropped during frame 3
    enable = 1'b1;
    tick;
    for (int f = 0; f < 2; f++) begin
      collect(16, 3, 1'b0, 1'b1);
      check_writes("cont");
      finish_frame(int'($urandom_range(20, 1)), int'($urandom_range(30, 3)), 1'b0);
      @(negedge clk);
      check("cont_busy", busy, 1'b1);
    end
    collect(8, 3, 1'b0, 1'b1);
    enable = 1'b0;
    collect(8, 3, 1'b0, 1'b1);
    check_writes("cont3");
    finish_frame(int'($urandom_range(20, 1)), int'($urandom_range(30, 3)), 1'b0);
    check("cont_fc3", frame_count, 16'd5);
    repeat (2) tick;
    @(negedge clk);
    check("cont_stop_busy", busy, 1'b0);

    // overrun in WAIT_FFT, set-wins over clear, then clear
    pulse_single();
    collect(16, 1, 1'b0, 1'b0);
    check_writes("ovr");
    sample_valid = 1'b1; sample_in = 16'($urandom);
    tick;
    sample_valid = 1'b0;
    tick;
    @(negedge clk);
    check("ovr_set", overrun, 1'b1);
    check("ovr_no_write", obs_addr.size(), 0);
    check("ovr_addr", addr, 4'hF);
    sample_valid = 1'b1; clear_err = 1'b1;
    tick;
    sample_valid = 1'b0; clear_err = 1'b0;
    @(negedge clk);
    check("ovr_set_wins", overrun, 1'b1);
    clear_err = 1'b1;
    tick;
    clear_err = 1'b0;
    @(negedge clk);
    check("ovr_clear", overrun, 1'b0);
    finish_frame(3, 10, 1'b0);

    // FFT timeout
    pulse_single();
    collect(16, 1, 1'b0, 1'b0);
    p0 = spi_pulses;
    repeat (TO - 1) tick;
    @(negedge clk);
    check("to_early", timeout_err, 1'b0);
    tick;
    @(negedge clk);
    check("to_set", timeout_err, 1'b1);
    tick;
    @(negedge clk);
    check("to_idle", busy, 1'b0);
    check("to_fc", frame_count, exp_fc);
    check("to_no_spi", spi_pulses - p0, 0);
    check_writes("to");
    clear_err = 1'b1;
    tick;
    clear_err = 1'b0;
    @(negedge clk);
    check("to_clear", timeout_err, 1'b0);

    // reset mid-frame after 7 samples
    pulse_single();
    collect(7, 1, 1'b0, 1'b0);
    check("mid_insert", insert_data, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_insert", insert_data, 1'b0);
    check("mid_rst_addr", addr, 4'h0);
    check("mid_rst_data", data_out, 16'h0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_fc", frame_count, 16'h0);
    exp_fc = 16'h0;
    wr_idx = 0;
    clear_queues();
    tick;
    rst = 1'b0;
    tick;
    pulse_single();
    collect(16, 1, 1'b0, 1'b0);
    check_writes("post_rst");
    finish_frame(4, 8, 1'b0);

    // frame_count wrap
    repeat (2) tick;
    force dut.frame_count = 16'hFFFF;
    tick;
    release dut.frame_count;
    tick;
    @(negedge clk);
    check("wrap_preset", frame_count, 16'hFFFF);
    exp_fc = 16'hFFFF;
    pulse_single();
    collect(16, 0, 1'b0, 1'b1);
    check_writes("wrap");
    finish_frame(2, 5, 1'b0);
    check("wrap_zero", frame_count, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
